conv_ctrl_gen: RTL
==================

Name: conv_ctrl_gen

Overview:
- Parametrised control unit for the streaming convolution filter.
- Loads a K×K coefficient kernel serially, then counts raster-order pixels of an IMG_W×IMG_H frame.
- Drives the line-buffer write strobe, the window-valid enable to the MAC datapath, and frame status.
- Generalises the fixed 3×3, square, single-frame controller:
  - kernel size, coefficient width and independent image width/height are parameters;
  - coefficients have a valid handshake;
  - row/column counters replace modulo arithmetic;
  - multi-frame operation and coefficient reload at frame boundaries are supported.

Parameters:
- IMG_W, 32, pixels per row (must be ≥ K)
- IMG_H, 32, rows per frame (must be ≥ K)
- K, 3, kernel side length (odd, ≥ 3)
- COEF_W, 8, coefficient width in bits

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- coeff_load  in  1  request to start kernel load
- coeff_valid  in  1  coeff_in valid this cycle
- coeff_in  in  COEF_W  coefficient value
- data_load  in  1  pixel presented to line buffer this cycle
- data_write  out  1  line-buffer write strobe
- enable  out  1  window valid, MAC may compute
- filter  out  K*K*COEF_W  packed kernel
- row  out  $clog2(IMG_H)  row of next expected pixel
- col  out  $clog2(IMG_W)  column of next expected pixel
- busy  out  1  high outside sIDLE/sRESET
- frame_done  out  1  one-cycle pulse after last pixel of frame

Behaviour:
- rst (sync, overrides everything, including mid-load/mid-frame):
  - state←sRESET, counters←0, kernel register←0.
  - Registered outputs enable and frame_done ←0; all combinational outputs evaluate to 0.
- States, one-hot, in shared package: sRESET, sIDLE, sLOADC, sSTREAM.
- sRESET → sIDLE unconditionally next cycle.
- sIDLE: coeff_load=1 → sLOADC; coefficient counter cleared.
- sLOADC:
  - Each cycle with coeff_valid=1: kernel ← (kernel << COEF_W) | coeff_in; coef_cnt++.
  - coeff_valid=0 cycles hold state and counter.
  - When the K*K-th coefficient is accepted, transition directly to sSTREAM on the same edge. No idle cycle.
  - First coefficient ends in the MS slice, last in bits [COEF_W-1:0].
- filter = kernel when state==sSTREAM, else 0.
- sSTREAM:
  - data_write = data_load (combinational, same cycle). 0 in all other states.
  - Each data_load: col++. At col==IMG_W-1, col←0 and row++.
  - At row==IMG_H-1 and col==IMG_W-1: row←0, col←0, and frame_done pulses next cycle.
- enable (registered):
  - High one cycle after a pixel is accepted at (row≥K-1 && col≥K-1), i.e. exactly (IMG_H-K+1)×(IMG_W-K+1) pulses per frame.
  - Never asserted for pixels whose window would wrap a row edge.
- data_load gaps: counters hold; enable and frame_done stay 0 on gap cycles.
- Frame end: behaviour per Optional Feature.
- Reload: coeff_load in sSTREAM with row==0, col==0 and data_load==0 → sLOADC (kernel reloaded, old values shifted out).
  - coeff_load at any other point in sSTREAM is ignored.
- data_load outside sSTREAM and coeff_valid outside sLOADC are ignored.
- busy = state∈{sLOADC, sSTREAM}.

Optional Feature:
- Macro CONV_AUTO_REARM_EN.
- Defined: after the last pixel the FSM stays in sSTREAM with counters wrapped to 0. The next frame streams with the same kernel.
- Undefined: after the last pixel the FSM goes to sIDLE, and filter drops to 0. The next frame requires coeff_load plus a full kernel load.
- frame_done pulses identically in both builds.

Decomposition:
- Package conv_pkg holds:
  - the state enum typedef;
  - width localparam helpers for row, col and coef_cnt ($clog2-based);
  - a constant for K*K.
- One natural sub-module: coeff_shift_reg, parametrised on K and COEF_W, with load/valid inputs and packed output. Used by conv_ctrl_gen.

Test Plan (K=3, IMG_W=IMG_H=4, COEF_W=8 unless noted):
- Reset, coeff_load, coefficients 1..9 with coeff_valid every cycle → sSTREAM after 9th accept; filter=72'h010203040506070809.
- Same load with coeff_valid low on alternate cycles → identical filter; state stays sLOADC until the 9th valid.
- Stream 16 contiguous pixels:
  - data_write high for all 16;
  - enable pulses 4 times, one cycle after pixels 11, 12, 15, 16 (1-based);
  - frame_done pulses once after pixel 16.
- Stream with random data_load gaps → same 4 enable pulses relative to accepted pixels; no pulses on gap cycles.
- Assert rst after pixel 9 → next cycle all outputs 0, state sRESET, then sIDLE; a new load and frame behave normally.
- Second frame:
  - with CONV_AUTO_REARM_EN → 4 more enable pulses with no reload;
  - without it → FSM in sIDLE, filter=0, data_write stays 0 for the second frame.

Source files
------------

// File: rtl/conv_pkg.sv
// Shared types and width helpers for the streaming convolution control unit.
package conv_pkg;

  typedef enum logic [3:0] {
    sRESET  = 4'b0001,
    sIDLE   = 4'b0010,
    sLOADC  = 4'b0100,
    sSTREAM = 4'b1000
  } state_e;

  localparam int unsigned DEF_IMG_W  = 32;
  localparam int unsigned DEF_IMG_H  = 32;
  localparam int unsigned DEF_K      = 3;
  localparam int unsigned DEF_COEF_W = 8;
  localparam int unsigned DEF_KK     = DEF_K * DEF_K;

  // A counter over n values needs at least one bit even when n is 1.
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int unsigned kk(input int unsigned k);
    return k * k;
  endfunction

  function automatic int unsigned row_w(input int unsigned img_h);
    return cnt_w(img_h);
  endfunction

  function automatic int unsigned col_w(input int unsigned img_w);
    return cnt_w(img_w);
  endfunction

  function automatic int unsigned coef_cnt_w(input int unsigned k);
    return cnt_w(kk(k));
  endfunction

endpackage

// File: rtl/conv_ctrl_gen_if.sv
// Handshake and status bundle between a pixel/coefficient source and conv_ctrl_gen.
interface conv_ctrl_gen_if
  import conv_pkg::*;
#(
  parameter int unsigned IMG_W  = DEF_IMG_W,
  parameter int unsigned IMG_H  = DEF_IMG_H,
  parameter int unsigned K      = DEF_K,
  parameter int unsigned COEF_W = DEF_COEF_W
) ();

  localparam int unsigned FILT_W = kk(K) * COEF_W;
  localparam int unsigned ROW_W  = row_w(IMG_H);
  localparam int unsigned COL_W  = col_w(IMG_W);

  logic              coeff_load;
  logic              coeff_valid;
  logic [COEF_W-1:0] coeff_in;
  logic              data_load;
  logic              data_write;
  logic              enable;
  logic [FILT_W-1:0] filter;
  logic [ROW_W-1:0]  row;
  logic [COL_W-1:0]  col;
  logic              busy;
  logic              frame_done;

  modport master (
    output coeff_load, coeff_valid, coeff_in, data_load,
    input  data_write, enable, filter, row, col, busy, frame_done
  );

  modport slave (
    input  coeff_load, coeff_valid, coeff_in, data_load,
    output data_write, enable, filter, row, col, busy, frame_done
  );

endinterface

// File: rtl/conv_ctrl_gen_coeff_shift_reg.sv
// Serial K*K coefficient loader: first accepted coefficient ends in the top slice.
module coeff_shift_reg
  import conv_pkg::*;
#(
  parameter int unsigned K      = DEF_K,
  parameter int unsigned COEF_W = DEF_COEF_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_load,
  input  logic                     i_valid,
  input  logic [COEF_W-1:0]        i_coeff,
  output logic [kk(K)*COEF_W-1:0]  o_kernel,
  output logic                     o_last
);

  localparam int unsigned KK    = kk(K);
  localparam int unsigned KW    = KK * COEF_W;
  localparam int unsigned CNT_W = coef_cnt_w(K);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(KK - 1);

  logic [KW-1:0]    r_kernel;
  logic [CNT_W-1:0] r_cnt;

  assign o_last   = i_valid && (r_cnt == CNT_LAST);
  assign o_kernel = r_kernel;

  // NOTE: state is written with <= so every flop samples pre-edge values; = here would chain updates within one edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the kernel is a small flop bank, not a RAM, so clearing it on reset is cheap and keeps filter defined.
      r_kernel <= '0;
      r_cnt    <= '0;
    end else if (i_load) begin
      r_cnt <= '0;
    end else if (i_valid) begin
      r_kernel <= {r_kernel[KW-COEF_W-1:0], i_coeff};
      r_cnt    <= o_last ? '0 : r_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/conv_ctrl_gen.sv
// Convolution filter controller: kernel load, raster pixel counting, window enable.
// Define CONV_AUTO_REARM_EN to keep streaming frames with the same kernel after frame end.
module conv_ctrl_gen
  import conv_pkg::*;
#(
  parameter int unsigned IMG_W  = DEF_IMG_W,
  parameter int unsigned IMG_H  = DEF_IMG_H,
  parameter int unsigned K      = DEF_K,
  parameter int unsigned COEF_W = DEF_COEF_W
) (
  input logic             clk,
  input logic             rst,
  conv_ctrl_gen_if.slave  bus
);

  localparam int unsigned KW    = kk(K) * COEF_W;
  localparam int unsigned ROW_W = row_w(IMG_H);
  localparam int unsigned COL_W = col_w(IMG_W);

  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0] ROW_WIN  = ROW_W'(K - 1);
  localparam logic [COL_W-1:0] COL_WIN  = COL_W'(K - 1);

  state_e           r_state;
  state_e           w_state_nxt;
  logic [ROW_W-1:0] r_row;
  logic [COL_W-1:0] r_col;
  logic             r_enable;
  logic             r_frame_done;

  logic             w_live;
  logic             w_in_stream;
  logic             w_in_loadc;
  logic             w_accept;
  logic             w_last_col;
  logic             w_last_row;
  logic             w_frame_end;
  logic             w_in_window;
  logic             w_reload;
  logic             w_coef_clear;
  logic             w_coef_valid;
  logic             w_coef_last;
  logic [KW-1:0]    w_kernel;

  // Gating with rst forces every combinational output to 0 during the reset cycle itself.
  assign w_live      = !rst;
  assign w_in_stream = w_live && (r_state == sSTREAM);
  assign w_in_loadc  = w_live && (r_state == sLOADC);

  assign w_accept    = w_in_stream && bus.data_load;
  assign w_last_col  = (r_col == COL_LAST);
  assign w_last_row  = (r_row == ROW_LAST);
  assign w_frame_end = w_accept && w_last_row && w_last_col;
  assign w_in_window = (r_row >= ROW_WIN) && (r_col >= COL_WIN);

  // Reload only between frames, so a partially streamed frame never sees a kernel swap.
  assign w_reload     = w_in_stream && bus.coeff_load && !bus.data_load
                        && (r_row == '0) && (r_col == '0);
  assign w_coef_clear = (w_live && (r_state == sIDLE) && bus.coeff_load) || w_reload;
  assign w_coef_valid = w_in_loadc && bus.coeff_valid;

  coeff_shift_reg #(
    .K      (K),
    .COEF_W (COEF_W)
  ) u_coeff (
    .clk      (clk),
    .rst      (rst),
    .i_load   (w_coef_clear),
    .i_valid  (w_coef_valid),
    .i_coeff  (bus.coeff_in),
    .o_kernel (w_kernel),
    .o_last   (w_coef_last)
  );

  always_comb begin
    // NOTE: defaulting the next state first means no path through the case leaves it unassigned, so no latch.
    w_state_nxt = r_state;
    case (r_state)
      sRESET:  w_state_nxt = sIDLE;
      sIDLE:   if (bus.coeff_load) w_state_nxt = sLOADC;
      sLOADC:  if (w_coef_last) w_state_nxt = sSTREAM;
      sSTREAM: begin
        if (w_reload) begin
          w_state_nxt = sLOADC;
        end else if (w_frame_end) begin
`ifdef CONV_AUTO_REARM_EN
          w_state_nxt = sSTREAM;
`else
          w_state_nxt = sIDLE;
`endif
        end
      end
      default: w_state_nxt = sRESET;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= sRESET;
      r_row        <= '0;
      r_col        <= '0;
      r_enable     <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_enable     <= w_accept && w_in_window;
      r_frame_done <= w_frame_end;
      if (w_accept) begin
        if (w_last_col) begin
          r_col <= '0;
          r_row <= w_last_row ? '0 : r_row + ROW_W'(1);
        end else begin
          r_col <= r_col + COL_W'(1);
        end
      end
    end
  end

  assign bus.data_write = w_accept;
  assign bus.enable     = r_enable;
  assign bus.frame_done = r_frame_done;
  assign bus.filter     = w_in_stream ? w_kernel : '0;
  assign bus.row        = r_row;
  assign bus.col        = r_col;
  assign bus.busy       = w_in_stream || w_in_loadc;

endmodule
